// File: rtl/bus_pkg.sv
// Shared types and constants for the pin bus responder.
// Holds the FSM state enum, frame header layout and frame byte counts.
package bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX_HOLD,
      S_TX_REL,
      S_RX_WAIT,
      S_RX_REL,
      S_RESP
   } state_t;

   localparam int HDR_WRITE    = 7;
   localparam int HDR_WSTRB_HI = 3;
   localparam int HDR_WSTRB_LO = 0;

   localparam int LOAD_TX_BYTES  = 5;
   localparam int STORE_TX_BYTES = 9;
   localparam int LOAD_RX_BYTES  = 4;
   localparam int STORE_RX_BYTES = 1;

   // Byte idx of the outgoing frame: header, addr LSB first, wdata LSB first.
   function automatic logic [7:0] frame_byte(
      input logic        write,
      input logic [31:0] addr,
      input logic [31:0] wdata,
      input logic [3:0]  wstrb,
      input logic [3:0]  idx
   );
      logic [7:0] b;
      b = '0;
      case (idx)
         4'd0: begin
            b[HDR_WRITE] = write;
            if (write)
               b[HDR_WSTRB_HI:HDR_WSTRB_LO] = wstrb;
         end
         4'd1: b = addr[7:0];
         4'd2: b = addr[15:8];
         4'd3: b = addr[23:16];
         4'd4: b = addr[31:24];
         4'd5: b = wdata[7:0];
         4'd6: b = wdata[15:8];
         4'd7: b = wdata[23:16];
         4'd8: b = wdata[31:24];
         default: b = '0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for one asynchronous pin input.
// Ports: clk, rst_n (sync, active-low), d (async in), q (synchronised out).
module sync_ff #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (!rst_n)
         ff <= '0;
      else
         ff <= {ff[SYNC_STAGES-2:0], d};
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/pin_bus_responder.sv
// CPU memory-bus responder that tunnels load/store requests to a host over
// 4-phase pin handshakes. Ports: req_* (CPU request), resp_* (CPU response),
// tx_data/tx_req/tx_ack (frame to host), rx_data/rx_req/rx_ack (host reply).
module pin_bus_responder
   import bus_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [7:0]  tx_data,
   output logic        tx_req,
   input  logic        tx_ack,
   input  logic [7:0]  rx_data,
   input  logic        rx_req,
   output logic        rx_ack
);

   state_t      state;
   logic [3:0]  cnt;
   logic        r_write;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        ack_s;
   logic        rxreq_s;
   logic [3:0]  tx_last;
   logic [3:0]  rx_last;

   sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ack (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (tx_ack),
      .q     (ack_s)
   );

   sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rxreq (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_req),
      .q     (rxreq_s)
   );

   assign tx_last = r_write ? 4'(STORE_TX_BYTES - 1) : 4'(LOAD_TX_BYTES - 1);
   assign rx_last = r_write ? 4'(STORE_RX_BYTES - 1) : 4'(LOAD_RX_BYTES - 1);

   // Accept is a same-cycle pulse so tx_req can rise on the very next edge.
   assign req_ready = rst_n && (state == S_IDLE) && req_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         tx_data    <= '0;
         tx_req     <= 1'b0;
         rx_ack     <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (req_valid) begin
                  r_write    <= req_write;
                  r_addr     <= req_addr;
                  r_wdata    <= req_wdata;
                  r_wstrb    <= req_write ? req_wstrb : 4'd0;
                  tx_data    <= frame_byte(req_write, req_addr,
                                           req_wdata, req_wstrb, 4'd0);
                  tx_req     <= 1'b1;
                  cnt        <= '0;
                  // Doubles as the load assembly buffer; stays 0 for stores.
                  resp_rdata <= '0;
                  state      <= S_TX_HOLD;
               end
            end
            S_TX_HOLD: begin
               if (ack_s) begin
                  tx_req <= 1'b0;
                  state  <= S_TX_REL;
               end
            end
            S_TX_REL: begin
               if (!ack_s) begin
                  if (cnt == tx_last) begin
                     cnt   <= '0;
                     state <= S_RX_WAIT;
                  end else begin
                     cnt     <= cnt + 4'd1;
                     tx_data <= frame_byte(r_write, r_addr, r_wdata,
                                           r_wstrb, cnt + 4'd1);
                     tx_req  <= 1'b1;
                     state   <= S_TX_HOLD;
                  end
               end
            end
            S_RX_WAIT: begin
               if (rxreq_s) begin
                  if (!r_write)
                     resp_rdata[{cnt[1:0], 3'b000} +: 8] <= rx_data;
                  rx_ack <= 1'b1;
                  state  <= S_RX_REL;
               end
            end
            S_RX_REL: begin
               if (!rxreq_s) begin
                  rx_ack <= 1'b0;
                  if (cnt == rx_last) begin
                     cnt        <= '0;
                     resp_valid <= 1'b1;
                     state      <= S_RESP;
                  end else begin
                     cnt   <= cnt + 4'd1;
                     state <= S_RX_WAIT;
                  end
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pin_bus_responder.sv
// Scoreboard bench for pin_bus_responder with a behavioural host model.
// Host emulates 4-phase pin handshakes with optional random delays.
module tb_pin_bus_responder;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [7:0]  tx_data;
   logic        tx_req;
   logic        tx_ack = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_req = 1'b0;
   logic        rx_ack;

   pin_bus_responder #(.SYNC_STAGES(S)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .tx_data    (tx_data),
      .tx_req     (tx_req),
      .tx_ack     (tx_ack),
      .rx_data    (rx_data),
      .rx_req     (rx_req),
      .rx_ack     (rx_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  txq[$];
   logic [31:0] respq[$];
   logic [31:0] replyq[$];

   int cyc = 0;
   int last_resp_cyc = -10;
   bit slow = 0;
   bit noise = 0;
   bit abort = 0;

   int ack_hi = 0, ack_lo = 0, rq_hi = 0, rq_lo = 0;

   int hst = 0, hdly = 0, hidx = 0, hlen = 5, hbi = 0, hrxlen = 4;
   logic [31:0] hreply = '0;
   logic [7:0]  hb;

   logic p_txreq = 0, p_rxack = 0, p_resp = 0, p_rst = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   function automatic int rdly();
      return slow ? int'($urandom_range(0, 20)) : 0;
   endfunction

   always @(posedge clk) begin
      cyc++;
      ack_hi = tx_ack ? ack_hi + 1 : 0;
      ack_lo = tx_ack ? 0 : ack_lo + 1;
      rq_hi  = rx_req ? rq_hi + 1 : 0;
      rq_lo  = rx_req ? 0 : rq_lo + 1;
   end

   // Monitor checks first, then host actions, in one process per negedge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && p_rst === 1'b1) begin
            if (p_txreq && !tx_req)
               chk("tx_req_fall_lat", ack_hi, S + 1);
            if (!p_txreq && tx_req) begin
               chk("tx_req_rise_host", hst, 0);
               if (hidx > 0)
                  chk("tx_req_rise_lat", ack_lo, S + 1);
            end
            if (!p_rxack && rx_ack) begin
               chk("rx_ack_rise_lat", rq_hi, S + 1);
               chk("rx_ack_phase", hst, 6);
            end
            if (p_rxack && !rx_ack)
               chk("rx_ack_fall_lat", rq_lo, S + 1);
            if (resp_valid) begin
               chk("resp_single", p_resp, 0);
               chk("resp_lat", rq_lo, S + 1);
               if (respq.size() == 0)
                  fail("resp_unexpected");
               else
                  chk("resp_rdata", resp_rdata, respq.pop_front());
               last_resp_cyc = cyc;
            end
         end
         p_txreq = tx_req;
         p_rxack = rx_ack;
         p_resp  = resp_valid;
         p_rst   = rst_n;

         if (abort) begin
            tx_ack = 0; rx_req = 0; rx_data = '0;
            hst = 0; hidx = 0; hbi = 0; abort = 0;
         end else begin
            case (hst)
               0: if (tx_req === 1'b1) begin hdly = rdly(); hst = 1; end
               1: begin
                  if (noise && hidx >= 1)
                     rx_req = (hdly >= 3 && hdly <= 4);
                  if (hdly == 0) begin
                     rx_req = 0;
                     hb = tx_data;
                     if (txq.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL tx_extra: byte %h, none expected", hb);
                     end else
                        chk("tx_byte", hb, txq.pop_front());
                     if (hidx == 0) begin
                        hlen   = hb[7] ? 9 : 5;
                        hrxlen = hb[7] ? 1 : 4;
                     end
                     hidx++;
                     tx_ack = 1;
                     hst = 2;
                  end else hdly--;
               end
               2: if (tx_req === 1'b0) begin hdly = rdly(); hst = 3; end
               3: if (hdly == 0) begin
                     tx_ack = 0;
                     if (hidx == hlen) begin hst = 4; hbi = 0; end
                     else hst = 0;
                  end else hdly--;
               4: begin
                  if (hbi == 0)
                     hreply = (replyq.size() != 0) ? replyq.pop_front() : 32'h0;
                  rx_data = 8'(hreply >> (8 * hbi));
                  hdly = rdly();
                  hst = 5;
               end
               5: if (hdly == 0) begin rx_req = 1; hst = 6; end
                  else hdly--;
               6: if (rx_ack === 1'b1) begin
                     rx_data = 8'($urandom);
                     hdly = rdly();
                     hst = 7;
                  end
               7: if (hdly == 0) begin rx_req = 0; hst = 8; end
                  else hdly--;
               8: if (rx_ack === 1'b0) begin
                     hbi++;
                     if (hbi == hrxlen) begin hst = 0; hidx = 0; end
                     else hst = 4;
                  end
               default: hst = 0;
            endcase
         end
      end
   end

   task automatic issue(input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] reply, input bit keep,
                        input bit b2b, input bit scr);
      int n;
      txq.push_back(w ? (8'h80 | {4'h0, s}) : 8'h00);
      for (int i = 0; i < 4; i++) txq.push_back(8'(a >> (8 * i)));
      if (w)
         for (int i = 0; i < 4; i++) txq.push_back(8'(d >> (8 * i)));
      replyq.push_back(w ? (reply & 32'hFF) : reply);
      respq.push_back(w ? 32'h0 : reply);
      @(negedge clk);
      #2;
      req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
      req_valid = 1;
      #1;
      n = 0;
      while (req_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         #3;
         n++;
      end
      if (req_ready !== 1'b1) begin
         fail("req_ready_timeout");
         req_valid = 0;
         return;
      end
      if (b2b) chk("b2b_gap", cyc, last_resp_cyc + 1);
      @(posedge clk);
      #1;
      chk("tx_req_after_accept", tx_req, 1);
      chk("req_ready_busy", req_ready, 0);
      if (!keep) begin
         req_valid = 0;
         if (scr) begin
            req_write = ~w; req_addr = $urandom; req_wdata = $urandom;
            req_wstrb = 4'($urandom);
         end
      end
   endtask

   task automatic wait_all();
      int n = 0;
      while (respq.size() != 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (respq.size() != 0) fail("resp_timeout");
      repeat (3) @(negedge clk);
   endtask

   task automatic rand_txn(input bit scr);
      bit w = 1'($urandom_range(0, 1));
      issue(w, $urandom, $urandom, 4'($urandom), $urandom, 0, 0, scr);
      wait_all();
   endtask

   initial begin
      int n;
      repeat (4) @(negedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_req", tx_req, 0);
      chk("rst_rx_ack", rx_ack, 0);
      #1 rst_n = 1;

      issue(0, 32'h0000_1004, 32'h0, 4'h0, 32'h0010_0513, 0, 0, 0);
      wait_all();
      issue(1, 32'h8000_0000, 32'hDEAD_BEEF, 4'h3, 32'h5A, 0, 0, 0);
      wait_all();
      issue(1, 32'h1234_5678, 32'hCAFE_F00D, 4'h0, 32'hA5, 0, 0, 0);
      wait_all();

      for (int i = 0; i < 12; i++) rand_txn(0);

      slow = 1;
      noise = 1;
      for (int i = 0; i < 10; i++) rand_txn(1);
      slow = 0;
      noise = 0;

      issue(0, 32'h0000_5A00, 32'h0, 4'h0, 32'h1111_2222, 0, 0, 0);
      n = 0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while (!(hidx == 2 && tx_req === 1'b1) && n < 2000);
      if (n >= 2000) fail("third_byte_timeout");
      rst_n = 0;
      abort = 1;
      txq.delete();
      respq.delete();
      replyq.delete();
      @(posedge clk);
      #1;
      chk("abort_req_ready", req_ready, 0);
      chk("abort_resp_valid", resp_valid, 0);
      chk("abort_resp_rdata", resp_rdata, 0);
      chk("abort_tx_data", tx_data, 0);
      chk("abort_tx_req", tx_req, 0);
      chk("abort_rx_ack", rx_ack, 0);
      @(negedge clk);
      #2 rst_n = 1;
      repeat (20) @(negedge clk);

      issue(0, 32'h0000_2000, 32'h0, 4'h0, 32'h89AB_CDEF, 0, 0, 0);
      wait_all();

      issue(0, $urandom, $urandom, 4'h0, $urandom, 1, 0, 0);
      issue(1, $urandom, $urandom, 4'hF, 32'h3C, 1, 1, 0);
      issue(0, $urandom, $urandom, 4'h0, $urandom, 1, 1, 0);
      issue(1, $urandom, $urandom, 4'h6, 32'hC3, 0, 1, 0);
      wait_all();

      chk("txq_drained", txq.size(), 0);
      chk("replyq_drained", replyq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      fail("watchdog");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pin_bus_responder.md
# pin_bus_responder

Memory-bus responder that lets the `cpu` core run from host-side memory through the TinyTapeout pins. It accepts one CPU load/store request at a time and sends it to the host as a byte frame over a 4-phase pin handshake. It collects the host's reply bytes and returns a single-cycle response to the core. It sits inside `tt_um_riscv_cpu_erwanregy`, between `cpu` and `uo_out`/`ui_in`/`uio_*`.

## Interface
- `SYNC_STAGES`, default 2: flops on each asynchronous pin input (`tx_ack`, `rx_req`); legal values ≥ 2.
- `clk`  in  1: core clock.
- `rst_n`  in  1: reset; synchronous, active-low.
- `req_valid`  in  1: CPU request pending; held with its fields until `req_ready`.
- `req_ready`  out  1: one-cycle accept pulse.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data.
- `req_wstrb`  in  4: store byte enables.
- `resp_valid`  out  1: one-cycle completion pulse.
- `resp_rdata`  out  32: load data; valid with `resp_valid`.
- `tx_data`  out  8: frame byte to host (`uo_out`).
- `tx_req`  out  1: byte valid (`uio_out[0]`).
- `tx_ack`  in  1: host ack (`uio_in[1]`), asynchronous.
- `rx_data`  in  8: reply byte from host (`ui_in`).
- `rx_req`  in  1: reply byte valid (`uio_in[2]`), asynchronous.
- `rx_ack`  out  1: reply captured (`uio_out[3]`).

## Operation
- Frame to host: header byte `{req_write, 3'b000, wstrb}`. The wstrb field is forced to 0 for loads. The header is followed by 4 address bytes, LSB first. Stores then send 4 wdata bytes, LSB first. Frame length: load 5 bytes, store 9 bytes.
- Reply from host: loads return 4 data bytes, LSB first. Stores return 1 ack byte; its value is ignored. For stores, `resp_rdata` = 0.
- Request capture: in IDLE with `req_valid`=1, pulse `req_ready` and register write/addr/wdata/wstrb. Later changes on the `req_*` inputs do not affect the frame.
- TX 4-phase handshake, per byte:
  - Drive `tx_data` and raise `tx_req`.
  - Wait for synchronised `tx_ack`=1, then drop `tx_req`.
  - Wait for synchronised `tx_ack`=0 before starting the next byte.
- RX 4-phase handshake, per byte:
  - Wait for synchronised `rx_req`=1.
  - Capture `rx_data` that same cycle and raise `rx_ack`.
  - Wait for synchronised `rx_req`=0, then drop `rx_ack`.
  - The host holds `rx_data` stable from before raising `rx_req` until it sees `rx_ack`.
- States and transitions:
  - IDLE → TX_HOLD on accept.
  - TX_HOLD (`tx_req`=1) → TX_REL on ack high.
  - TX_REL → TX_HOLD (next byte), or → RX_WAIT after the last byte, on ack low.
  - RX_WAIT → RX_REL on `rx_req` high.
  - RX_REL (`rx_ack`=1) → RX_WAIT (next byte), or → RESP after the last byte, on `rx_req` low.
  - RESP → IDLE; `resp_valid`=1 for that one cycle.
- Byte counter: 4 bits. It counts 0..8 in TX and 0..3 in RX, and is cleared on every phase change.
- `rx_req` is ignored in every state except RX_WAIT. `tx_ack` is ignored in IDLE and the RX states.
- `wstrb`=0 on a store still sends the full 9-byte frame.
- A new request is not accepted before RESP completes; `req_ready` stays 0 outside IDLE.

## Timing
- Reset values (`rst_n`=0 at a clock edge): state IDLE, all outputs 0 (`req_ready`, `resp_valid`, `resp_rdata`, `tx_data`, `tx_req`, `rx_ack`), synchroniser flops 0, counter 0.
- Reset mid-transaction drops the transaction with no `resp_valid`. The host detects the abort from `tx_req`/`rx_ack` falling.
- `req_ready` is asserted in the cycle `req_valid` is first seen in IDLE. `tx_req` rises on the next edge.
- Pin input to state reaction: `SYNC_STAGES` cycles, plus 1 cycle for the registered output change.
- `resp_valid` is asserted exactly one cycle after the final `rx_req` fall is seen. The earliest next `req_ready` is the cycle after `resp_valid`.
- Minimum per byte with an instant host: 2×(`SYNC_STAGES`+1) cycles.

## Structure
- Shared package `bus_pkg`:
  - state enum;
  - header bit positions (`HDR_WRITE`=7, `HDR_WSTRB`=3:0);
  - `LOAD_TX_BYTES`=5, `STORE_TX_BYTES`=9, `LOAD_RX_BYTES`=4, `STORE_RX_BYTES`=1.
- One sub-module `sync_ff`: parameterised `SYNC_STAGES` synchroniser, instantiated for `tx_ack` and for `rx_req`.

## Test plan
- Load addr 0x0000_1004, host replies bytes 0x13,0x05,0x10,0x00 → TX bytes 0x00,0x04,0x10,0x00,0x00; `resp_rdata`=0x0010_0513 with one `resp_valid` pulse.
- Store addr 0x8000_0000, wdata 0xDEAD_BEEF, wstrb 0x3 → TX bytes 0x83,0x00,0x00,0x00,0x80,0xEF,0xBE,0xAD,0xDE; host ack byte 0x5A → `resp_rdata`=0.
- Slow host adding 0–20 random cycles at every handshake edge → identical bytes and result; `tx_req`/`rx_ack` never toggle before the opposite edge has been synchronised.
- `rx_req` pulsed during TX phase, and `req_*` changed after `req_ready` → no capture, frame unchanged.
- `rst_n` low during the 3rd TX byte → next cycle all outputs 0 and no `resp_valid`; a following load completes normally.
- Back-to-back requests with `req_valid` held → second `req_ready` exactly one cycle after first `resp_valid`.
